// File: rtl/nv_nvdla_glb_pkg.sv
// nv_nvdla_glb_pkg: shared source IDs, source count and coalescing FSM encoding for the GLB interrupt scheduler
package nv_nvdla_glb_pkg;
  localparam int NUM_SRC = 12;
  localparam int ID_W = 4;
  localparam logic [ID_W-1:0] SRC_SDP0 = 4'd0;
  localparam logic [ID_W-1:0] SRC_SDP1 = 4'd1;
  localparam logic [ID_W-1:0] SRC_CDP0 = 4'd2;
  localparam logic [ID_W-1:0] SRC_CDP1 = 4'd3;
  localparam logic [ID_W-1:0] SRC_PDP0 = 4'd4;
  localparam logic [ID_W-1:0] SRC_PDP1 = 4'd5;
  localparam logic [ID_W-1:0] SRC_CDMA_DAT0 = 4'd6;
  localparam logic [ID_W-1:0] SRC_CDMA_DAT1 = 4'd7;
  localparam logic [ID_W-1:0] SRC_CDMA_WT0 = 4'd8;
  localparam logic [ID_W-1:0] SRC_CDMA_WT1 = 4'd9;
  localparam logic [ID_W-1:0] SRC_CACC0 = 4'd10;
  localparam logic [ID_W-1:0] SRC_CACC1 = 4'd11;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } coal_st_e;
endpackage

// File: rtl/nv_nvdla_glb_intr_fifo.sv
// nv_nvdla_glb_intr_fifo: show-ahead synchronous FIFO with occupancy count
module nv_nvdla_glb_intr_fifo #(
  parameter int W = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     vld_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i & (cnt_q != '0);
  assign do_push = push_i & (cnt_q != (AW+1)'(DEPTH));
  assign vld_o = cnt_q != '0;
  assign cnt_o = cnt_q;
  assign dout_o = vld_o ? mem_q[rd_q] : '0;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset; the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/nv_nvdla_glb_intr_sched.sv
// nv_nvdla_glb_intr_sched: done-pulse capture, round-robin event FIFO and interrupt coalescing (optional NVDLA_GLB_INTR_SCHED_STAMP_EN adds per-event cycle stamps)
module nv_nvdla_glb_intr_sched
  import nv_nvdla_glb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TMO_W = 16
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  input  logic [NUM_SRC-1:0]            done_pulse,
  input  logic [NUM_SRC-1:0]            done_mask,
  input  logic                          evt_rd_req,
  output logic                          evt_rd_vld,
  output logic [ID_W-1:0]               evt_rd_id,
  output logic [$clog2(FIFO_DEPTH):0]   evt_cnt,
  input  logic [$clog2(FIFO_DEPTH):0]   coal_thresh,
  input  logic [TMO_W-1:0]              coal_timeout,
  input  logic                          intr_ack,
  output logic                          core_intr,
  output logic                          ovf_sticky,
  input  logic                          ovf_clr
`ifdef NVDLA_GLB_INTR_SCHED_STAMP_EN
  ,
  output logic [TMO_W-1:0]              evt_rd_stamp
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef NVDLA_GLB_INTR_SCHED_STAMP_EN
  localparam int FW = ID_W + TMO_W;
`else
  localparam int FW = ID_W;
`endif
  logic [NUM_SRC-1:0] pend_q, pend_d, cand, gnt_oh;
  logic [ID_W-1:0] rr_q, rr_d, gnt_id;
  logic gnt_vld, ovf_q, ovf_d, intr_q, fire;
  logic [CW-1:0] thr;
  logic [TMO_W-1:0] tmr_q;
  coal_st_e st_q;
  logic [FW-1:0] fifo_din, fifo_dout;

  function automatic logic [ID_W:0] rr_pick(logic [NUM_SRC-1:0] c, logic [ID_W-1:0] ptr);
    logic [ID_W:0] r, s;
    r = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      s = (ID_W+1)'(ptr) + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(NUM_SRC)) s = s - (ID_W+1)'(NUM_SRC);
      if (c[s[ID_W-1:0]]) r = {1'b1, s[ID_W-1:0]};
    end
    return r;
  endfunction

  // arbitration, pending/overflow next state and coalescing fire condition
  always_comb begin
    cand = pend_q & ~done_mask;
    {gnt_vld, gnt_id} = (evt_cnt < CW'(FIFO_DEPTH)) ? rr_pick(cand, rr_q) : '0;
    gnt_oh = gnt_vld ? NUM_SRC'(1) << gnt_id : '0;
    pend_d = (pend_q & ~gnt_oh) | done_pulse;
    ovf_d = (|(done_pulse & pend_q & ~gnt_oh)) | (ovf_q & ~ovf_clr);
    rr_d = !gnt_vld ? rr_q : (gnt_id == ID_W'(NUM_SRC - 1)) ? '0 : gnt_id + 1'b1;
    thr = (coal_thresh == '0) ? CW'(1) : coal_thresh;
    fire = (evt_cnt >= thr) || (coal_timeout != '0 && tmr_q == coal_timeout);
  end

  // pending bitmap, round-robin pointer and overflow flag
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      pend_q <= '0;
      rr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      rr_q <= rr_d;
      ovf_q <= ovf_d;
    end
  end

  // coalescing FSM; core_intr is registered alongside the FIRE state
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      st_q <= ST_IDLE;
      tmr_q <= '0;
      intr_q <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          tmr_q <= '0;
          if (evt_cnt != '0) st_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (evt_cnt == '0) begin
            st_q <= ST_IDLE;
            tmr_q <= '0;
          end else if (fire) begin
            st_q <= ST_FIRE;
            intr_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMO_W'(~&tmr_q);
          end
        end
        ST_FIRE: begin
          if (intr_ack) begin
            tmr_q <= '0;
            intr_q <= 1'b0;
            st_q <= (evt_cnt != '0) ? ST_ARMED : ST_IDLE;
          end
        end
        default: begin
          st_q <= ST_IDLE;
          intr_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef NVDLA_GLB_INTR_SCHED_STAMP_EN
  logic [TMO_W-1:0] stamp_q;
  // free-running cycle stamp recorded with every pushed event
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) stamp_q <= '0;
    else stamp_q <= stamp_q + 1'b1;
  end
  assign fifo_din = {stamp_q, gnt_id};
  assign {evt_rd_stamp, evt_rd_id} = fifo_dout;
`else
  assign fifo_din = gnt_id;
  assign evt_rd_id = fifo_dout;
`endif

  nv_nvdla_glb_intr_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (nvdla_core_clk),
    .rst    (nvdla_core_rst),
    .push_i (gnt_vld),
    .din_i  (fifo_din),
    .pop_i  (evt_rd_req),
    .dout_o (fifo_dout),
    .vld_o  (evt_rd_vld),
    .cnt_o  (evt_cnt)
  );

  assign core_intr = intr_q;
  assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_nv_nvdla_glb_intr_sched.sv
// tb_nv_nvdla_glb_intr_sched: directed and random checks against a queue-based reference model
module tb_nv_nvdla_glb_intr_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req, ack, clr;
  logic [11:0] pulse, mask;
  logic [3:0] thresh;
  logic [15:0] tmo;
  logic vld, intr, ovf;
  logic [3:0] id, cnt;
`ifdef NVDLA_GLB_INTR_SCHED_STAMP_EN
  logic [15:0] stamp;
`endif
  int ncmp = 0;
  int nerr = 0;
  int q[$];
  bit pend[12];
  int rr, mode, age, k;
  bit movf, mintr;

  nv_nvdla_glb_intr_sched dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .done_pulse     (pulse),
    .done_mask      (mask),
    .evt_rd_req     (req),
    .evt_rd_vld     (vld),
    .evt_rd_id      (id),
    .evt_cnt        (cnt),
    .coal_thresh    (thresh),
    .coal_timeout   (tmo),
    .intr_ack       (ack),
    .core_intr      (intr),
    .ovf_sticky     (ovf),
    .ovf_clr        (clr)
`ifdef NVDLA_GLB_INTR_SCHED_STAMP_EN
    ,
    .evt_rd_stamp   (stamp)
`endif
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int c, g, th, x;
    bit s;
    if (rst) begin
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      rr = 0; movf = 0; mode = 0; age = 0; mintr = 0;
      return;
    end
    c = q.size();
    g = -1;
    if (c < 8)
      for (int j = 0; j < 12; j++) begin
        x = (rr + j) % 12;
        if (g < 0 && pend[x] && !mask[x]) g = x;
      end
    s = 0;
    for (int i = 0; i < 12; i++) if (pulse[i] && pend[i] && i != g) s = 1;
    movf = s || (movf && !clr);
    for (int i = 0; i < 12; i++) pend[i] = (i == g) ? pulse[i] : (pend[i] | pulse[i]);
    if (g >= 0) rr = (g + 1) % 12;
    th = (thresh == 0) ? 1 : int'(thresh);
    if (mode == 0) begin
      age = 0;
      if (c > 0) mode = 1;
    end else if (mode == 1) begin
      if (c == 0) begin mode = 0; age = 0; end
      else if (c >= th || (tmo != 0 && age == int'(tmo))) mode = 2;
      else if (age < 65535) age++;
    end else if (ack) begin
      age = 0;
      mode = (c > 0) ? 1 : 0;
    end
    mintr = (mode == 2);
    if (req && c > 0) void'(q.pop_front());
    if (g >= 0) q.push_back(g);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("cnt", cnt, q.size());
    chk("vld", vld, q.size() > 0);
    chk("id", id, (q.size() > 0) ? q[0] : 0);
    chk("intr", intr, mintr);
    chk("ovf", ovf, movf);
    pulse = '0;
    clr = 1'b0;
  endtask

  initial begin
    rst = 1; pulse = '0; mask = '0; req = 0; ack = 0; clr = 0; thresh = 4'd3; tmo = '0;
    tick(); tick();
    rst = 0;
    chk("rst_cnt", cnt, 0);
    chk("rst_vld", vld, 0);
    chk("rst_intr", intr, 0);
    // three simultaneous sources drain in round-robin order
    pulse = 12'h811;
    tick(); tick(); tick(); tick();
    chk("s1_intr_early", intr, 0);
    tick();
    chk("s1_intr", intr, 1);
    chk("s1_cnt", cnt, 3);
    chk("s1_head0", id, 0);
    req = 1; tick();
    chk("s1_head1", id, 4);
    tick();
    chk("s1_head2", id, 11);
    tick(); req = 0;
    chk("s1_empty", cnt, 0);
    ack = 1; tick(); ack = 0;
    chk("s1_ack", intr, 0);
    // masked source stays pending until unmasked
    mask = 12'h004; pulse = 12'h004; tick(); tick();
    pulse = 12'h008; tick(); tick(); tick();
    chk("s2_cnt", cnt, 1);
    chk("s2_head", id, 3);
    req = 1; tick(); req = 0;
    mask = '0; tick();
    chk("s2_unmask", id, 2);
    req = 1; tick(); req = 0;
    // full FIFO blocks grants
    thresh = 4'd0; pulse = 12'hFFF;
    repeat (12) tick();
    chk("s3_full", cnt, 8);
    req = 1; tick(); req = 0;
    chk("s3_pop", cnt, 7);
    tick();
    chk("s3_refill", cnt, 8);
    req = 1; repeat (16) tick(); req = 0;
    chk("s3_drain", cnt, 0);
    ack = 1; tick(); ack = 0;
    // age timeout fires with threshold unreached
    thresh = 4'd8; tmo = 16'd20;
    pulse = 12'h080; tick(); tick(); tick();
    k = 0;
    while (!intr && k < 40) begin tick(); k++; end
    chk("s4_tmo_lat", (k >= 21 && k <= 22), 1);
    req = 1; tick(); req = 0;
    ack = 1; tick(); ack = 0;
    chk("s4_idle", intr, 0);
    // overflow merges and set beats clear
    tmo = '0; clr = 1; tick();
    chk("s5_pre", ovf, 0);
    mask = 12'h020; pulse = 12'h020; tick();
    pulse = 12'h020; tick();
    chk("s5_ovf", ovf, 1);
    mask = '0; tick(); tick();
    chk("s5_single", cnt, 1);
    chk("s5_id", id, 5);
    mask = 12'h020; pulse = 12'h020; req = 1; tick(); req = 0;
    pulse = 12'h020; clr = 1; tick();
    chk("s5_set_wins", ovf, 1);
    clr = 1; tick();
    chk("s5_clr", ovf, 0);
    mask = '0; tick(); tick();
    req = 1; repeat (3) tick(); req = 0;
    // reset mid-operation
    thresh = 4'd3; pulse = 12'h01F;
    repeat (8) tick();
    chk("s6_cnt", cnt, 5);
    chk("s6_intr", intr, 1);
    rst = 1; tick(); rst = 0;
    chk("s6_cnt0", cnt, 0);
    chk("s6_vld0", vld, 0);
    chk("s6_id0", id, 0);
    chk("s6_intr0", intr, 0);
    tick();
    chk("s6_stays", cnt, 0);
    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        thresh = 4'($urandom_range(0, 9));
        tmo = 16'($urandom_range(0, 25));
      end
      pulse = 12'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) mask = 12'($urandom & $urandom);
      req = ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      rst = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
